grouper_input_loader: RTL

- Upstream stage of the grouper: accepts a raw byte stream over a valid/ready handshake and packs it into the grouper's input memory as zero-separated words, ending the buffer with a double zero.
- When the buffer is complete it pulses the grouper's cs, waits for the grouper's done, then reports completion.
- It owns the input-memory write port until it hands off to the grouper; it never writes while the grouper runs.

---
 rtl/grouper_input_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/grouper_input_loader.sv
// Upstream loader for the grouper: packs a valid/ready byte stream into the grouper's
// input memory as zero-separated words, adds the double-zero terminator, then kicks the grouper.
module grouper_input_loader #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SEP_CHAR   = 8'h20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  grp_cs,
  input  logic                  grp_done,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] word_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Highest address a data byte may use; the two slots above it are kept for terminators.
  localparam logic [ADDR_WIDTH-1:0] LAST_DATA_ADDR = ADDR_WIDTH'(DEPTH - 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TERM_A,
    S_TERM_B,
    S_KICK,
    S_WAIT
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic                  r_word_open;
  logic [ADDR_WIDTH-1:0] r_word_count;
  logic                  r_overflow;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_grp_cs;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_is_sep;
  logic                  w_data_fits;
  logic [ADDR_WIDTH-1:0] w_word_count_inc;

  assign in_ready    = (r_state == S_LOAD);
  assign busy        = (r_state != S_IDLE);
  assign w_accept    = in_valid & in_ready;
  assign w_is_sep    = (in_data == '0) || (in_data == SEP_CHAR);
  assign w_data_fits = (r_wptr <= LAST_DATA_ADDR);
  assign w_word_count_inc = (&r_word_count) ? r_word_count : r_word_count + 1'b1;

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign grp_cs     = r_grp_cs;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign word_count = r_word_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wptr       <= '0;
      r_word_open  <= 1'b0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_grp_cs     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here turn every strobe set below into a one-cycle pulse;
      // later assignments in the same block override them without any ordering hazard.
      r_mem_we <= 1'b0;
      r_grp_cs <= 1'b0;
      r_done   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_wptr       <= '0;
            r_word_open  <= 1'b0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
            r_state      <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (w_accept) begin
            if (!w_is_sep) begin
              if (w_data_fits) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_wptr;
                r_mem_wdata <= in_data;
                r_wptr      <= r_wptr + 1'b1;
                r_word_open <= 1'b1;
              end else begin
                r_overflow <= 1'b1;
              end
            end else if (r_word_open) begin
              // Only the first separator after a word writes; repeats collapse.
              r_mem_we     <= 1'b1;
              r_mem_addr   <= r_wptr;
              r_mem_wdata  <= '0;
              r_wptr       <= r_wptr + 1'b1;
              r_word_open  <= 1'b0;
              r_word_count <= w_word_count_inc;
            end
            if (in_last) r_state <= S_TERM_A;
          end
        end

        S_TERM_A: begin
          // Close an open word, or lay the first zero of an empty buffer.
          if (r_word_open || (r_wptr == '0)) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_wptr;
            r_mem_wdata <= '0;
            r_wptr      <= r_wptr + 1'b1;
            if (r_word_open) begin
              r_word_count <= w_word_count_inc;
              r_word_open  <= 1'b0;
            end
          end
          r_state <= S_TERM_B;
        end

        S_TERM_B: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_wptr;
          r_mem_wdata <= '0;
          r_grp_cs    <= 1'b1;
          r_state     <= S_KICK;
        end

        S_KICK: begin
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (grp_done) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
